// File: rtl/sumador_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial adder controller.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF = 8;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sumador_completo.sv
// Single full adder shared by the serial controller; PwrC picks the gate formulation.
module sumador_completo #(
  parameter int PwrC = 0
) (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  generate
    if (PwrC != 0) begin : g_prop
      // Propagate term is shared between sum and carry to cut toggling logic.
      logic w_p;
      assign w_p  = i_a ^ i_b;
      assign o_s  = w_p ^ i_ci;
      assign o_co = (w_p & i_ci) | (i_a & i_b);
    end else begin : g_maj
      assign o_s  = i_a ^ i_b ^ i_ci;
      assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);
    end
  endgenerate

endmodule

// File: rtl/sumador_serie_ctrl.sv
// Bit-serial N-bit adder: one shared full adder, LSB first, one bit per cycle.
// Operands accepted only in IDLE; result held in DONE until out_ready, clr aborts to IDLE.
module sumador_serie_ctrl
  import sumador_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int PwrC = 0
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CW = cnt_width(N);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_a_sh;
  logic [N-1:0]    r_b_sh;
  logic [N-1:0]    r_s_sh;
  logic [N-1:0]    r_s;
  logic            r_co;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    w_s_sh_nxt;
  logic            w_sum;
  logic            w_cout;
  logic            w_last;
  logic            w_accept;

  assign w_accept = (r_state == IDLE) && in_valid && !clr;
  assign w_last   = (r_cnt == CW'(N - 1));

  sumador_completo #(.PwrC(PwrC)) u_fa (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_cout)
  );

  generate
    if (N == 1) begin : g_n1
      assign w_s_sh_nxt = w_sum;
    end else begin : g_nw
      assign w_s_sh_nxt = {w_sum, r_s_sh[N-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid)  w_state_nxt = SUMA;
        SUMA:    if (w_last)    w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= b;
        r_carry <= ci;
        r_cnt   <= '0;
      end else if ((r_state == SUMA) && !clr) begin
        r_a_sh  <= r_a_sh >> 1;
        r_b_sh  <= r_b_sh >> 1;
        r_s_sh  <= w_s_sh_nxt;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + 1'b1;
        // Last bit goes straight into the result register, not via the shifter.
        if (w_last) begin
          r_s  <= w_s_sh_nxt;
          r_co <= w_cout;
        end
      end
    end
  end

  // Counting the handshake cycle as the first, out_valid shows up N+1 cycles later.
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == SUMA);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign co        = r_co;

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Randomised scoreboard bench for sumador_serie_ctrl, N=8 instance plus an N=1 instance.
module tb_sumador_serie_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_L, clr, in_valid, in_ready, ci, co, out_valid, out_ready, busy;
  logic [N-1:0] a, b, s;

  logic         rst1_n, clr1, in_valid1, in_ready1, ci1, co1, out_valid1, out_ready1, busy1;
  logic [0:0]   a1, b1, s1;

  int total  = 0;
  int passes = 0;
  int cyc    = 0;
  bit done1  = 1'b0;

  logic [N:0] exp_q[$];
  int         acc_q[$];
  logic       prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sumador_serie_ctrl #(.N(N), .PwrC(0)) u_dut (
    .clk(clk), .reset_L(reset_L), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .s(s), .co(co), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  sumador_serie_ctrl #(.N(1), .PwrC(1)) u_dut1 (
    .clk(clk), .reset_L(rst1_n), .clr(clr1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .s(s1), .co(co1), .out_valid(out_valid1),
    .out_ready(out_ready1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic c);
    return (N+1)'(x) + (N+1)'(y) + (N+1)'(c);
  endfunction

  // Scoreboard monitor: latency on each rising out_valid, value on each handshake.
  always @(negedge clk) begin
    if (!reset_L) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else                   chk("latency", cyc - acc_q[0], N + 1);
      end
      if (out_valid && out_ready && acc_q.size() != 0) begin
        chk("result", {co, s}, exp_q[0]);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ici,
                       input bit track, output int acc_at);
    int n;
    n = 0;
    a = ia; b = ib; ci = ici; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    acc_at = cyc;
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else if (track) begin
      exp_q.push_back(model(ia, ib, ici));
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); ci = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  logic [2*N:0] vec [4] = '{ {8'h0F, 8'h01, 1'b0}, {8'hFF, 8'h01, 1'b0},
                             {8'h00, 8'h00, 1'b1}, {8'hFF, 8'hFF, 1'b1} };
  logic [N:0]   vexp[4] = '{ 9'h010, 9'h100, 9'h001, 9'h1FF };

  initial begin
    int acc, prev_acc, n;
    logic [N:0] last;
    reset_L = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;

    for (int i = 0; i < 4; i++) begin
      issue(vec[i][2*N:N+1], vec[i][N:1], vec[i][0], 1'b1, acc);
      drain();
      chk($sformatf("directed_%0d", i), {co, s}, vexp[i]);
    end

    // Back-pressure with ignored operand pulses in DONE.
    out_ready = 1'b0;
    last = model(8'h5A, 8'hC3, 1'b1);
    issue(8'h5A, 8'hC3, 1'b1, 1'b1, acc);
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = N'($urandom); b = N'($urandom); ci = 1'($urandom);
      @(negedge clk);
      chk("hold_result", {co, s}, last);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Abort while cnt==3.
    issue(8'hAA, 8'h55, 1'b0, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_keep", {co, s}, last);
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      chk("clr_no_valid", out_valid, 0);
    end

    // clr collides with an accept in IDLE.
    @(posedge clk); #1;
    in_valid = 1'b1; clr = 1'b1; a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("clr_acc_busy", busy, 0);
    chk("clr_acc_keep", {co, s}, last);
    @(posedge clk); #1;
    issue(8'h12, 8'h34, 1'b0, 1'b1, acc);
    drain();
    chk("after_clr", {co, s}, 9'h046);

    // Asynchronous reset in the middle of SUMA.
    issue(8'h77, 8'h88, 1'b1, 1'b0, acc);
    repeat (2) @(posedge clk);
    #3 reset_L = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_s", s, 0);
    chk("arst_co", co, 0);
    @(posedge clk); #1 reset_L = 1'b1;
    issue(8'h77, 8'h88, 1'b1, 1'b1, acc);
    drain();
    chk("recovery", {co, s}, 9'h100);

    // Back-to-back random traffic; consecutive accepts must be N+2 apart.
    prev_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      issue(N'($urandom), N'($urandom), 1'($urandom), 1'b1, acc);
      if (i > 0) chk("throughput", acc - prev_acc, N + 2);
      prev_acc = acc;
    end
    drain();

    n = 0;
    while (!done1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!done1) chk("n1_timeout", out_valid1, 1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // N=1 build: one SUMA cycle, so out_valid two cycles after the handshake cycle.
  initial begin
    logic [1:0] e;
    int n, t0;
    rst1_n = 1'b0; clr1 = 1'b0; out_ready1 = 1'b1; in_valid1 = 1'b0;
    a1 = '0; b1 = '0; ci1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst1_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      e = 2'(a1) + 2'(b1) + 2'(ci1);
      in_valid1 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      t0 = cyc;
      @(posedge clk); #1;
      in_valid1 = 1'b0; a1 = ~a1; b1 = ~b1; ci1 = ~ci1;
      chk("n1_busy", busy1, 1);
      n = 0;
      @(negedge clk);
      while (!out_valid1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("n1_latency", cyc - t0, 2);
      chk("n1_result", {co1, s1}, e);
    end
    done1 = 1'b1;
  end

endmodule
